deadlock_persist_monitor: RTL and testbench

Per-kernel deadlock detector that consumes the AXI-Stream blocking flags and per-instance idle/block flags that the kernel monitor top gathers, and decides whether the kernel is truly deadlocked. It filters transient back-pressure with a persistence counter, latches a sticky `block` flag, and snapshots which stream interfaces were stalled at the moment of detection. It sits directly downstream of the kernel monitor top in the co-simulation deadlock-checking path.

---
 rtl/deadlock_mon_pkg.sv | 19 +
 rtl/deadlock_stall_reduce.sv | 37 +++
 rtl/deadlock_persist_monitor.sv | 160 ++++++++++++++++
 tb/tb_deadlock_persist_monitor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/deadlock_mon_pkg.sv
// -----------------------------------------------------------------------------
// deadlock_mon_pkg
//   Shared definitions for the kernel deadlock monitors.
//   - state_e       : detector FSM states (IDLE, SUSPECT, BLOCKED)
//   - DEF_THRESHOLD : default persistence threshold in stall cycles
//   - DEF_CNT_W     : default width of the stall-duration counter
// -----------------------------------------------------------------------------
package deadlock_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SUSPECT = 2'd1,
    BLOCKED = 2'd2
  } state_e;

  localparam int DEF_THRESHOLD = 1024;
  localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/deadlock_stall_reduce.sv
// -----------------------------------------------------------------------------
// deadlock_stall_reduce
//   Combinational stall-condition reducer shared by the kernel monitors.
//   Ports:
//     axis_block_sigs [N_AXIS] in  : 1 = stream interface blocked
//     inst_idle_sigs  [N_INST] in  : 1 = instance idle
//     inst_block_sigs [N_INST] in  : 1 = instance blocked on a channel
//     stall                    out : kernel currently looks stalled
// -----------------------------------------------------------------------------
module deadlock_stall_reduce #(
  parameter int N_AXIS = 2,
  parameter int N_INST = 1
) (
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_INST-1:0] inst_idle_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  output logic              stall
);

  logic all_quiet;
  logic any_block;
  logic all_idle;
  logic inst_reported;
  logic inst_stall;

  assign all_quiet = &(inst_idle_sigs | inst_block_sigs);
  assign any_block = (|axis_block_sigs) | (|inst_block_sigs);
  assign all_idle  = &inst_idle_sigs;
  assign inst_stall = all_quiet & any_block & ~all_idle;

  // When no instance reports anything (all per-instance flags tied low, as in
  // kernels without monitored sub-instances) the instance terms carry no
  // information and the stall decision falls back to the stream flags alone.
  assign inst_reported = |(inst_idle_sigs | inst_block_sigs);
  assign stall = inst_reported ? inst_stall : (|axis_block_sigs);

endmodule

// File: rtl/deadlock_persist_monitor.sv
// -----------------------------------------------------------------------------
// deadlock_persist_monitor
//   Per-kernel deadlock detector. Filters transient back-pressure with a
//   persistence counter, raises a sticky block flag once a stall has lasted
//   THRESHOLD cycles, and snapshots the blocked stream interfaces.
//   Optional feature macro: DEADLOCK_SNAPSHOT_EN
//     defined   : axis_snapshot captured on detection, stall_cycles keeps
//                 counting while BLOCKED
//     undefined : axis_snapshot tied 0, stall_cycles frozen at THRESHOLD
//   Ports:
//     clock, reset_n (async, active-low)
//     axis_block_sigs [N_AXIS], inst_idle_sigs [N_INST], inst_block_sigs [N_INST]
//     clear          : acknowledge and re-arm
//     block          : sticky deadlock flag (registered)
//     suspect        : stall in progress below threshold (registered)
//     stall_cycles   : current / latched stall length, saturating
//     axis_snapshot  : axis_block_sigs captured on the detection cycle
// -----------------------------------------------------------------------------
module deadlock_persist_monitor
  import deadlock_mon_pkg::*;
#(
  parameter int N_AXIS    = 2,
  parameter int N_INST    = 1,
  parameter int THRESHOLD = DEF_THRESHOLD,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_INST-1:0] inst_idle_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  input  logic              clear,
  output logic              block,
  output logic              suspect,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [N_AXIS-1:0] axis_snapshot
);

  localparam logic [31:0] THR_U = 32'(THRESHOLD);
`ifndef DEADLOCK_SNAPSHOT_EN
  localparam logic [CNT_W-1:0] THR_CNT = CNT_W'(THRESHOLD);
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             stall;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             block_q, block_d;
  logic             suspect_q, suspect_d;

  deadlock_stall_reduce #(
    .N_AXIS (N_AXIS),
    .N_INST (N_INST)
  ) u_reduce (
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .stall           (stall)
  );

  assign cnt_inc = sat_inc(cnt_q);

`ifdef DEADLOCK_SNAPSHOT_EN
  logic [N_AXIS-1:0] snap_q, snap_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef DEADLOCK_SNAPSHOT_EN
    snap_d  = snap_q;
`endif
    // clear overrides any stall seen on the same edge
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
`ifdef DEADLOCK_SNAPSHOT_EN
      snap_d  = '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (stall) begin
            state_d = SUSPECT;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d   = '0;
          end
        end
        SUSPECT: begin
          if (stall) begin
            cnt_d = cnt_inc;
            // Evaluated only from SUSPECT, so THRESHOLD=1 still spends one
            // cycle in SUSPECT before BLOCKED.
            if (32'(cnt_inc) >= THR_U) begin
              state_d = BLOCKED;
`ifdef DEADLOCK_SNAPSHOT_EN
              snap_d  = axis_block_sigs;
`else
              cnt_d   = THR_CNT;
`endif
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        BLOCKED: begin
`ifdef DEADLOCK_SNAPSHOT_EN
          if (stall) begin
            cnt_d = cnt_inc;
          end
`endif
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    block_d   = (state_d == BLOCKED);
    suspect_d = (state_d == SUSPECT);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      block_q   <= 1'b0;
      suspect_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      block_q   <= block_d;
      suspect_q <= suspect_d;
    end
  end

`ifdef DEADLOCK_SNAPSHOT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      snap_q <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end
  assign axis_snapshot = snap_q;
`else
  assign axis_snapshot = '0;
`endif

  assign block        = block_q;
  assign suspect      = suspect_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_deadlock_persist_monitor.sv
// -----------------------------------------------------------------------------
// tb_deadlock_persist_monitor
//   Directed bench for deadlock_persist_monitor with THRESHOLD=4, N_AXIS=2,
//   N_INST=1 (instance inputs tied 0). Two instances share the stimulus:
//   u0 with CNT_W=16 and u1 with CNT_W=3 (counter saturation).
//   Works in both builds of DEADLOCK_SNAPSHOT_EN.
// -----------------------------------------------------------------------------
module tb_deadlock_persist_monitor;

`ifdef DEADLOCK_SNAPSHOT_EN
  localparam bit SNAP_EN = 1'b1;
`else
  localparam bit SNAP_EN = 1'b0;
`endif
  localparam int THR = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] axis;
  logic [0:0] inst_idle  = 1'b0;
  logic [0:0] inst_block = 1'b0;
  logic       clear;

  logic        u0_block, u0_suspect, u1_block, u1_suspect;
  logic [15:0] u0_cnt;
  logic [2:0]  u1_cnt;
  logic [1:0]  u0_snap, u1_snap;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  always #5 clock = ~clock;

  deadlock_persist_monitor #(
    .N_AXIS(2), .N_INST(1), .THRESHOLD(THR), .CNT_W(16)
  ) u0 (
    .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis),
    .inst_idle_sigs(inst_idle), .inst_block_sigs(inst_block), .clear(clear),
    .block(u0_block), .suspect(u0_suspect), .stall_cycles(u0_cnt),
    .axis_snapshot(u0_snap)
  );

  deadlock_persist_monitor #(
    .N_AXIS(2), .N_INST(1), .THRESHOLD(THR), .CNT_W(3)
  ) u1 (
    .clock(clock), .reset_n(reset_n), .axis_block_sigs(axis),
    .inst_idle_sigs(inst_idle), .inst_block_sigs(inst_block), .clear(clear),
    .block(u1_block), .suspect(u1_suspect), .stall_cycles(u1_cnt),
    .axis_snapshot(u1_snap)
  );

  // Model: run = number of consecutive stalled edges since the detector was
  // last armed (unbounded); blocked once the run reaches max(THR,2).
  typedef struct packed {
    bit         blk;
    int         run;
    logic [1:0] snap;
  } mstate_t;

  mstate_t m0 = '0;
  mstate_t m1 = '0;

  function automatic mstate_t mstep(input mstate_t s, input bit stall,
                                    input logic [1:0] a, input bit clr,
                                    input int thr);
    mstate_t n;
    int need;
    n = s;
    need = (thr < 2) ? 2 : thr;
    if (clr) begin
      n = '0;
    end else if (!s.blk) begin
      n.run = stall ? s.run + 1 : 0;
      if (n.run >= need) begin
        n.blk  = 1'b1;
        n.snap = a;
      end
    end else if (stall) begin
      n.run = s.run + 1;
    end
    return n;
  endfunction

  function automatic int exp_cnt(input mstate_t s, input int cntw, input int thr);
    int mx;
    mx = (1 << cntw) - 1;
    if (!SNAP_EN && s.blk) return thr;
    return (s.run > mx) ? mx : s.run;
  endfunction

  function automatic int exp_snap(input mstate_t s);
    return SNAP_EN ? int'(s.snap) : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= mstep(m0, |axis, axis, clear, THR);
      m1 <= mstep(m1, |axis, axis, clear, THR);
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("cmp u0.block",   int'(u0_block),   int'(m0.blk));
      chk("cmp u0.suspect", int'(u0_suspect), int'(!m0.blk && m0.run > 0));
      chk("cmp u0.cnt",     int'(u0_cnt),     exp_cnt(m0, 16, THR));
      chk("cmp u0.snap",    int'(u0_snap),    exp_snap(m0));
      chk("cmp u1.block",   int'(u1_block),   int'(m1.blk));
      chk("cmp u1.suspect", int'(u1_suspect), int'(!m1.blk && m1.run > 0));
      chk("cmp u1.cnt",     int'(u1_cnt),     exp_cnt(m1, 3, THR));
      chk("cmp u1.snap",    int'(u1_snap),    exp_snap(m1));
    end
  end

  initial begin
    axis    = 2'b01;
    clear   = 1'b0;
    reset_n = 1'b0;
    @(posedge clock); #1;
    cmp_en = 1'b1;
    @(posedge clock); #1;
    // reset held with a stall present
    chk("rst block",   int'(u0_block),   0);
    chk("rst suspect", int'(u0_suspect), 0);
    chk("rst cnt",     int'(u0_cnt),     0);
    chk("rst snap",    int'(u0_snap),    0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    chk("post-rst suspect", int'(u0_suspect), 1);
    chk("post-rst cnt",     int'(u0_cnt),     1);
    axis = 2'b00;
    @(posedge clock); #1;
    chk("idle suspect", int'(u0_suspect), 0);
    chk("idle cnt",     int'(u0_cnt),     0);

    // transient stall of 3 edges
    axis = 2'b10;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clock); #1;
      chk("short suspect", int'(u0_suspect), 1);
      chk("short block",   int'(u0_block),   0);
      chk("short cnt",     int'(u0_cnt),     i);
    end
    axis = 2'b00;
    @(posedge clock); #1;
    chk("short end suspect", int'(u0_suspect), 0);
    chk("short end block",   int'(u0_block),   0);
    chk("short end cnt",     int'(u0_cnt),     0);

    // full detection
    axis = 2'b10;
    repeat (3) @(posedge clock);
    #1;
    chk("det pre block",   int'(u0_block),   0);
    chk("det pre suspect", int'(u0_suspect), 1);
    @(posedge clock); #1;
    chk("det block",   int'(u0_block),   1);
    chk("det suspect", int'(u0_suspect), 0);
    chk("det cnt",     int'(u0_cnt),     4);
    chk("det snap",    int'(u0_snap),    SNAP_EN ? 2 : 0);

    // hold to 10 edges, then clear with stall still present
    repeat (6) @(posedge clock);
    #1;
    chk("hold10 u0 cnt", int'(u0_cnt), SNAP_EN ? 10 : 4);
    chk("hold10 u1 cnt", int'(u1_cnt), SNAP_EN ? 7 : 4);
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    chk("clr block",   int'(u0_block),   0);
    chk("clr suspect", int'(u0_suspect), 0);
    chk("clr cnt",     int'(u0_cnt),     0);
    chk("clr snap",    int'(u0_snap),    0);
    repeat (3) @(posedge clock);
    #1;
    chk("redet pre block", int'(u0_block), 0);
    @(posedge clock); #1;
    chk("redet block", int'(u0_block), 1);

    // asynchronous reset between edges while BLOCKED
    #2 reset_n = 1'b0;
    #1;
    chk("async u0 block",   int'(u0_block),   0);
    chk("async u0 suspect", int'(u0_suspect), 0);
    chk("async u0 cnt",     int'(u0_cnt),     0);
    chk("async u1 block",   int'(u1_block),   0);
    chk("async u1 cnt",     int'(u1_cnt),     0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // long stall: saturation of the 3-bit counter
    repeat (20) @(posedge clock);
    #1;
    chk("sat u0 cnt",   int'(u0_cnt),   SNAP_EN ? 20 : 4);
    chk("sat u1 cnt",   int'(u1_cnt),   SNAP_EN ? 7 : 4);
    chk("sat u1 block", int'(u1_block), 1);
    axis = 2'b00;
    repeat (3) @(posedge clock);
    #1;
    chk("freeze u1 cnt",   int'(u1_cnt),   SNAP_EN ? 7 : 4);
    chk("freeze u0 block", int'(u0_block), 1);

    @(negedge clock);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
